uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned ACT_TIMEOUT_DEF = 1023;
  localparam int unsigned BYTE_W          = 8;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACT  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_e;

  // Frame configuration handed to uart_tx.
  typedef struct packed {
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
  } tx_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester above last_winner, else lowest overall.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] above_mask;
  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] pick;

  // Bits strictly above last_winner; shifting 2 lets last_winner = N_REQ-1 wrap to an empty mask.
  assign above_mask = ~((N_REQ'(2) << last_winner) - N_REQ'(1));
  assign masked_req = req & above_mask;
  assign pick       = (|masked_req) ? masked_req : req;
  // Isolate the lowest set bit of the chosen vector.
  assign grant      = pick & (~pick + N_REQ'(1));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ requesters with round-robin grant and an activity timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [1:0]              cfg_baud_rate,
  input  logic [1:0]              cfg_parity_type,
  input  logic                    cfg_stop_bits,
  input  logic                    cfg_data_length,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        err,
  output logic                    tx_send,
  output logic [BYTE_W-1:0]       tx_data,
  output logic [1:0]              tx_baud_rate,
  output logic [1:0]              tx_parity_type,
  output logic                    tx_stop_bits,
  output logic                    tx_data_length,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic                    busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(ACT_TIMEOUT + 1);
  // The counter value on which the ACT_TIMEOUT-th waiting cycle is seen.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACT_TIMEOUT - 1);

  logic [N_REQ-1:0][BYTE_W-1:0] req_bytes;
  tx_cfg_t                      cfg_in;

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              send_q, send_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] data_q, data_d;
  tx_cfg_t           cfg_q, cfg_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]  rr_idx;

  assign req_bytes          = req_data;
  assign cfg_in.baud_rate   = cfg_baud_rate;
  assign cfg_in.parity_type = cfg_parity_type;
  assign cfg_in.stop_bits   = cfg_stop_bits;
  assign cfg_in.data_length = cfg_data_length;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (req),
    .last_winner (last_q),
    .grant       (rr_gnt)
  );

  // Convert the one-hot pick into an index for byte select and last_winner tracking.
  always_comb begin
    rr_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rr_gnt[i]) rr_idx = IDX_W'(i);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = '0;
    send_d   = 1'b0;
    data_d   = data_q;
    cfg_d    = cfg_q;
    last_d   = last_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d    = rr_gnt;
          winner_d = rr_idx;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = req_bytes[winner_q];
        cfg_d   = cfg_in;
        state_d = ST_START;
      end
      ST_START: begin
        send_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (tx_active && tx_done) begin
          // Frame finished before we saw it running: treat as completion.
          ack_d   = gnt_q;
          gnt_d   = '0;
          last_d  = winner_q;
          state_d = ST_IDLE;
        end else if (tx_active) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Rotate past a dead requester so it cannot starve the others.
          err_d   = gnt_q;
          gnt_d   = '0;
          last_d  = winner_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          ack_d   = gnt_q;
          gnt_d   = '0;
          last_d  = winner_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      cfg_q    <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      winner_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      send_q   <= send_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      cfg_q    <= cfg_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt            = gnt_q;
  assign ack            = ack_q;
  assign err            = err_q;
  assign tx_send        = send_q;
  assign tx_data        = data_q;
  assign tx_baud_rate   = cfg_q.baud_rate;
  assign tx_parity_type = cfg_q.parity_type;
  assign tx_stop_bits   = cfg_q.stop_bits;
  assign tx_data_length = cfg_q.data_length;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames vs. a round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 24;

  logic           clock = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [1:0]     cfg_baud_rate, cfg_parity_type;
  logic           cfg_stop_bits, cfg_data_length;
  logic [N-1:0]   gnt, ack, err;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic [1:0]     tx_baud_rate, tx_parity_type;
  logic           tx_stop_bits, tx_data_length;
  logic           tx_active, tx_done, busy;

  int checks = 0;
  int errors = 0;
  int model_last;

  uart_tx_arbiter #(.N_REQ(N), .ACT_TIMEOUT(TO)) dut (
    .clock           (clock),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .cfg_baud_rate   (cfg_baud_rate),
    .cfg_parity_type (cfg_parity_type),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_data_length (cfg_data_length),
    .gnt             (gnt),
    .ack             (ack),
    .err             (err),
    .tx_send         (tx_send),
    .tx_data         (tx_data),
    .tx_baud_rate    (tx_baud_rate),
    .tx_parity_type  (tx_parity_type),
    .tx_stop_bits    (tx_stop_bits),
    .tx_data_length  (tx_data_length),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Reference rule: scan requesters starting just after the previous winner, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    req       = '0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    rst       = 1'b1;
    @(negedge clock);
    rst        = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({gnt, ack, err} !== '0) begin
      errors++; $display("FAIL reset_gnt_ack_err got %b expected 0", {gnt, ack, err});
    end
    checks++;
    if ({tx_send, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_send_busy got %b expected 00", {tx_send, busy});
    end
    checks++;
    if ({tx_data, tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} !== 14'd0) begin
      errors++; $display("FAIL reset_data_cfg got %h expected 0",
                         {tx_data, tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length});
    end
    rst        = 1'b0;
    model_last = N - 1;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    req_data       = 32'($urandom);
    req_data[15:8] = 8'h74;
    req            = 4'b0010;
    tick(1);
    checks++;
    if (gnt !== 4'b0010 || busy !== 1'b1 || tx_send !== 1'b0) begin
      errors++; $display("FAIL single_grant got gnt=%b busy=%b send=%b expected 0010 1 0", gnt, busy, tx_send);
    end
    tick(1);
    checks++;
    if (tx_data !== 8'h74 || tx_send !== 1'b0) begin
      errors++; $display("FAIL single_data got %h send=%b expected 74 0", tx_data, tx_send);
    end
    tick(1);
    checks++;
    if (tx_send !== 1'b1) begin
      errors++; $display("FAIL single_send_cycle3 got %b expected 1", tx_send);
    end
    tx_active = 1'b1;
    tick(1);
    checks++;
    if (tx_send !== 1'b0) begin
      errors++; $display("FAIL single_send_width got %b expected 0", tx_send);
    end
    tick(1);
    tx_done = 1'b1;
    tick(1);
    checks++;
    if (ack !== 4'b0010 || gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_ack got ack=%b gnt=%b busy=%b expected 0010 0000 0", ack, gnt, busy);
    end
    tx_done   = 1'b0;
    tx_active = 1'b0;
    req       = '0;
    tick(1);
    checks++;
    if (ack !== 4'b0000) begin
      errors++; $display("FAIL single_ack_width got %b expected 0000", ack);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_oh;
    do_reset();
    req_data = 32'($urandom);
    req      = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      exp_oh = N'(1) << f;
      tick(1);
      checks++;
      if (gnt !== exp_oh) begin
        errors++; $display("FAIL contention_gnt frame %0d got %b expected %b", f, gnt, exp_oh);
      end
      tick(1);
      checks++;
      if (tx_data !== req_data[8*f +: 8]) begin
        errors++; $display("FAIL contention_data frame %0d got %h expected %h", f, tx_data, req_data[8*f +: 8]);
      end
      tick(1);
      checks++;
      if (tx_send !== 1'b1 || ack !== '0) begin
        errors++; $display("FAIL contention_send frame %0d got send=%b ack=%b expected 1 0000", f, tx_send, ack);
      end
      tx_active = 1'b1;
      tick(1);
      tx_done = 1'b1;
      tick(1);
      checks++;
      if (ack !== exp_oh || gnt !== '0) begin
        errors++; $display("FAIL contention_ack frame %0d got ack=%b gnt=%b expected %b 0000", f, ack, gnt, exp_oh);
      end
      tx_done   = 1'b0;
      tx_active = 1'b0;
    end
    req = '0;
    tick(2);
  endtask

  task automatic test_timeout();
    do_reset();
    req_data = 32'($urandom);
    req      = 4'b0011;
    tick(3);
    checks++;
    if (tx_send !== 1'b1 || gnt !== 4'b0001) begin
      errors++; $display("FAIL timeout_send got send=%b gnt=%b expected 1 0001", tx_send, gnt);
    end
    for (int j = 1; j < TO; j++) begin
      tick(1);
      checks++;
      if (err !== '0) begin
        errors++; $display("FAIL timeout_early cycle %0d got %b expected 0000", j, err);
      end
    end
    tick(1);
    checks++;
    if (err !== 4'b0001 || gnt !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err got err=%b gnt=%b busy=%b expected 0001 0000 0", err, gnt, busy);
    end
    tick(1);
    checks++;
    if (gnt !== 4'b0010 || err !== '0) begin
      errors++; $display("FAIL timeout_next_gnt got gnt=%b err=%b expected 0010 0000", gnt, err);
    end
    tick(2);
    tx_active = 1'b1;
    tick(1);
    tx_done = 1'b1;
    tick(1);
    checks++;
    if (ack !== 4'b0010) begin
      errors++; $display("FAIL timeout_next_ack got %b expected 0010", ack);
    end
    tx_done   = 1'b0;
    tx_active = 1'b0;
    req       = '0;
    tick(2);
  endtask

  task automatic test_cfg_latch();
    do_reset();
    req_data        = 32'($urandom);
    cfg_parity_type = 2'b01;
    req             = 4'b0100;
    tick(2);
    checks++;
    if (tx_parity_type !== 2'b01) begin
      errors++; $display("FAIL cfg_load got %b expected 01", tx_parity_type);
    end
    tick(1);
    tx_active = 1'b1;
    tick(1);
    cfg_parity_type = 2'b10;
    tick(1);
    checks++;
    if (tx_parity_type !== 2'b01) begin
      errors++; $display("FAIL cfg_hold_wait got %b expected 01", tx_parity_type);
    end
    tx_done = 1'b1;
    tick(1);
    checks++;
    if (ack !== 4'b0100 || tx_parity_type !== 2'b01) begin
      errors++; $display("FAIL cfg_hold_ack got ack=%b par=%b expected 0100 01", ack, tx_parity_type);
    end
    tx_done   = 1'b0;
    tx_active = 1'b0;
    tick(1);
    checks++;
    if (gnt !== 4'b0100 || tx_parity_type !== 2'b01) begin
      errors++; $display("FAIL cfg_hold_regrant got gnt=%b par=%b expected 0100 01", gnt, tx_parity_type);
    end
    tick(1);
    checks++;
    if (tx_parity_type !== 2'b10) begin
      errors++; $display("FAIL cfg_relatch got %b expected 10", tx_parity_type);
    end
    req = '0;
    tick(1);
    tx_active = 1'b1;
    tick(1);
    tx_done = 1'b1;
    tick(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    req_data        = 32'($urandom);
    req_data[23:16] = 8'hA5;
    cfg_baud_rate   = 2'b11;
    cfg_parity_type = 2'b11;
    cfg_stop_bits   = 1'b1;
    cfg_data_length = 1'b1;
    req             = 4'b0100;
    tick(3);
    tx_active = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL midrst_pre got busy=%b data=%h expected 1 a5", busy, tx_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, ack, err, tx_send, busy} !== '0 ||
        {tx_data, tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} !== 14'd0) begin
      errors++; $display("FAIL midrst_outputs got gnt=%b send=%b busy=%b data=%h expected all 0",
                         gnt, tx_send, busy, tx_data);
    end
    @(negedge clock);
    rst        = 1'b0;
    model_last = N - 1;
    tx_done    = 1'b1;
    req        = 4'b1101;
    tick(1);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    checks++;
    if (ack !== '0 || err !== '0 || gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_after got ack=%b err=%b gnt=%b expected 0000 0000 0001", ack, err, gnt);
    end
    tick(1);
    checks++;
    if (ack !== '0) begin
      errors++; $display("FAIL midrst_no_ack got %b expected 0000", ack);
    end
    req = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_data = 32'($urandom);
    req      = 4'b1000;
    tick(3);
    tx_active = 1'b1;
    tx_done   = 1'b1;
    req       = '0;
    tick(1);
    checks++;
    if (ack !== 4'b1000 || err !== '0 || gnt !== '0) begin
      errors++; $display("FAIL simult_ack got ack=%b err=%b gnt=%b expected 1000 0000 0000", ack, err, gnt);
    end
    tx_active = 1'b0;
    tx_done   = 1'b0;
    for (int j = 0; j < TO + 2; j++) begin
      tick(1);
      checks++;
      if (err !== '0 || ack !== '0) begin
        errors++; $display("FAIL simult_quiet cycle %0d got ack=%b err=%b expected 0", j, ack, err);
      end
    end
  endtask

  task automatic test_random_frames();
    int           w;
    int           d;
    int           len;
    logic [N-1:0] r;
    logic [N-1:0] exp_oh;
    logic [7:0]   exp_byte;
    logic [5:0]   exp_cfg;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      r        = N'($urandom_range(1, (1 << N) - 1));
      req      = r;
      req_data = 32'($urandom);
      {cfg_baud_rate, cfg_parity_type, cfg_stop_bits, cfg_data_length} = 6'($urandom);
      exp_cfg  = {cfg_baud_rate, cfg_parity_type, cfg_stop_bits, cfg_data_length};
      w        = rr_pick(r, model_last);
      exp_oh   = N'(1) << w;
      exp_byte = req_data[8*w +: 8];
      tick(1);
      checks++;
      if (gnt !== exp_oh || busy !== 1'b1) begin
        errors++; $display("FAIL rand_gnt frame %0d req=%b got %b busy=%b expected %b 1", f, r, gnt, busy, exp_oh);
      end
      tick(1);
      checks++;
      if (tx_data !== exp_byte ||
          {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} !== exp_cfg) begin
        errors++; $display("FAIL rand_load frame %0d got %h/%b expected %h/%b", f, tx_data,
                           {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length}, exp_byte, exp_cfg);
      end
      // Requester side may drop or change everything once the byte is captured.
      req      = N'($urandom);
      req_data = 32'($urandom);
      {cfg_baud_rate, cfg_parity_type, cfg_stop_bits, cfg_data_length} = 6'($urandom);
      tick(1);
      checks++;
      if (tx_send !== 1'b1) begin
        errors++; $display("FAIL rand_send frame %0d got %b expected 1", f, tx_send);
      end
      if ($urandom_range(0, 4) == 0) begin
        tick(TO - 1);
        checks++;
        if (err !== '0) begin
          errors++; $display("FAIL rand_err_early frame %0d got %b expected 0000", f, err);
        end
        tick(1);
        checks++;
        if (err !== exp_oh || ack !== '0 || gnt !== '0) begin
          errors++; $display("FAIL rand_err frame %0d got err=%b ack=%b gnt=%b expected %b 0000 0000",
                             f, err, ack, gnt, exp_oh);
        end
      end else begin
        d   = $urandom_range(0, TO - 2);
        len = $urandom_range(0, 3);
        tick(d);
        tx_active = 1'b1;
        if (len == 0) begin
          tx_done = 1'b1;
        end else begin
          tick(len);
          tx_done = 1'b1;
        end
        tick(1);
        checks++;
        if (ack !== exp_oh || err !== '0 || gnt !== '0 || tx_data !== exp_byte ||
            {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} !== exp_cfg) begin
          errors++; $display("FAIL rand_ack frame %0d got ack=%b err=%b gnt=%b data=%h expected %b 0000 0000 %h",
                             f, ack, err, gnt, tx_data, exp_oh, exp_byte);
        end
        tx_done   = 1'b0;
        tx_active = 1'b0;
      end
      model_last = w;
    end
    req = '0;
    tick(2);
  endtask

  initial begin
    rst             = 1'b1;
    req             = '0;
    req_data        = '0;
    cfg_baud_rate   = '0;
    cfg_parity_type = '0;
    cfg_stop_bits   = 1'b0;
    cfg_data_length = 1'b0;
    tx_active       = 1'b0;
    tx_done         = 1'b0;
    model_last      = N - 1;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_cfg_latch();
    test_reset_midframe();
    test_simultaneous();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

endmodule
